// File: rtl/disp_msg_ctrl_pkg.sv
// Shared definitions for the 7-seg display/message controller: glyph word layout,
// message state codes, FSM encodings and glyph/digit helpers.
package disp_msg_ctrl_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'd31;
    localparam logic [DIGITS-1:0]  AN_OFF      = 4'b1111;

    localparam logic [STATE_W-1:0] ST_HELP = 4'd6;
    localparam logic [STATE_W-1:0] ST_CLR  = 4'd8;
    localparam logic [STATE_W-1:0] ST_ADD  = 4'd9;
    localparam logic [STATE_W-1:0] ST_SUB  = 4'd10;
    localparam logic [STATE_W-1:0] ST_DOT  = 4'd11;
    localparam logic [STATE_W-1:0] ST_DIV  = 4'd12;
    localparam logic [STATE_W-1:0] ST_TEST = 4'd13;

    // d3 is the leftmost digit (bits [19:15])
    typedef struct packed {
        logic [GLYPH_W-1:0] d3;
        logic [GLYPH_W-1:0] d2;
        logic [GLYPH_W-1:0] d1;
        logic [GLYPH_W-1:0] d0;
    } glyph_word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_GAP  = 2'd2
    } fsm_e;

    function automatic logic is_msg_state(input logic [STATE_W-1:0] s);
        case (s)
            ST_HELP, ST_CLR, ST_ADD, ST_SUB, ST_DOT, ST_DIV, ST_TEST: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scan slot 0 drives the leftmost digit
    function automatic logic [GLYPH_W-1:0] pick_glyph(input glyph_word_t w,
                                                      input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return w.d3;
            2'd1:    return w.d2;
            2'd2:    return w.d1;
            default: return w.d0;
        endcase
    endfunction

    function automatic logic [DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return 4'b0111;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit scan timer: SCAN_DIV-cycle slot divider, 2-bit digit index and a one-cycle
// frame_tick registered on the index wrap 3->0.
module disp_scan_timer
    import disp_msg_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             frame_tick
);

    localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (div == DIV_LAST) begin
                div        <= '0;
                idx        <= idx + IDX_W'(1);
                frame_tick <= (idx == IDX_W'(DIGITS - 1));
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/disp_msg_ctrl.sv
// Display owner: shows num_code, or a latched message word for HOLD_CYC cycles followed
// by one blank gap frame. Optional blinking of messages under DISP_MSG_BLINK_EN.
module disp_msg_ctrl
    import disp_msg_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned HOLD_CYC  = 100000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STATE_W-1:0]   state,
    input  logic [19:0]          msg_code,
    input  logic [19:0]          num_code,
    output logic                 busy,
    output logic [DIGITS-1:0]    an,
    output logic [GLYPH_W-1:0]   seg_code,
    output logic                 frame_tick
);

    localparam int unsigned      HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic [IDX_W-1:0]   idx;
    logic [STATE_W-1:0] state_q;
    glyph_word_t        msg_q;
    glyph_word_t        word_c;
    logic [HOLD_W-1:0]  hold;
    logic               trig;
    logic               hold_last;
    logic               blink_off;
    fsm_e               fsm_q;
    fsm_e               fsm_d;

    disp_scan_timer #(
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .frame_tick (frame_tick)
    );

    // Only an edge into a message state triggers; a steady state never re-shows
    assign trig      = (state != state_q) && is_msg_state(state);
    assign hold_last = (hold == HOLD_LAST);
    assign word_c    = (fsm_q == S_MSG) ? msg_q : glyph_word_t'(num_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            msg_q   <= '0;
            hold    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state;
            if (trig) begin
                msg_q <= glyph_word_t'(msg_code);
                hold  <= '0;
            end else if (fsm_q == S_MSG) begin
                hold  <= hold_last ? '0 : hold + HOLD_W'(1);
            end
        end
    end

    // A trigger wins in every state, including over the gap-ending frame_tick
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (trig) fsm_d = S_MSG;
            S_MSG:   if (!trig && hold_last) fsm_d = S_GAP;
            S_GAP: begin
                if (trig)            fsm_d = S_MSG;
                else if (frame_tick) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

`ifdef DISP_MSG_BLINK_EN
    localparam int unsigned       BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase_off;

    always_ff @(posedge clk) begin
        if (rst || trig) begin
            blink_cnt       <= '0;
            blink_phase_off <= 1'b0;
        end else if (fsm_q == S_MSG) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt       <= '0;
                blink_phase_off <= ~blink_phase_off;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign blink_off = (fsm_q == S_MSG) && blink_phase_off;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_DIV != 0);
    assign blink_off        = 1'b0;
`endif

    // Digit drive lags idx by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            an       <= AN_OFF;
            seg_code <= GLYPH_BLANK;
            busy     <= 1'b0;
        end else begin
            busy <= (fsm_d != S_IDLE);
            if ((fsm_q == S_GAP) || blink_off) begin
                an       <= AN_OFF;
                seg_code <= GLYPH_BLANK;
            end else begin
                an       <= digit_enable(idx);
                seg_code <= pick_glyph(word_c, idx);
            end
        end
    end

endmodule

// File: tb/tb_disp_msg_ctrl.sv
// Randomized bench for disp_msg_ctrl against a timeline-based reference model
// (message start edge, hold deadline, frame boundaries). Honors DISP_MSG_BLINK_EN.
module tb_disp_msg_ctrl;

    localparam int SCAN  = 4;
    localparam int HOLD  = 64;
    localparam int BLINK = 8;
`ifdef DISP_MSG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam int M_NUM = 0, M_MSG = 1, M_BLANK = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  state;
    logic [19:0] msg_code;
    logic [19:0] num_code;
    logic        busy;
    logic [3:0]  an;
    logic [4:0]  seg_code;
    logic        frame_tick;

    int checks;
    int errors;

    // reference model
    int          m_k;
    int          m_mode;
    int          m_t;
    int          m_idx;
    bit          m_ft;
    bit          m_off;
    logic [3:0]  m_prev_state;
    logic [19:0] m_word;
    logic [3:0]  e_an;
    logic [4:0]  e_seg;
    logic        e_busy;
    logic        e_ft;

    disp_msg_ctrl #(
        .SCAN_DIV   (SCAN),
        .HOLD_CYC   (HOLD),
        .BLINK_DIV  (BLINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .msg_code   (msg_code),
        .num_code   (num_code),
        .busy       (busy),
        .an         (an),
        .seg_code   (seg_code),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_msg(input logic [3:0] s);
        return (s == 4'd6) || (s >= 4'd8 && s <= 4'd13);
    endfunction

    function automatic logic [4:0] glyph_of(input logic [19:0] w, input int i);
        logic [19:0] t;
        t = w >> (5 * (3 - i));
        return t[4:0];
    endfunction

    function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge, then move to
    // the falling edge where outputs are compared.
    task automatic tick();
        int          p_mode;
        int          p_idx;
        bit          p_off;
        bit          ft_prev;
        logic [19:0] p_word;
        logic [19:0] shown;
        logic [3:0]  an_tbl [4];
        bit          trig;
        an_tbl = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        @(posedge clk);
        if (rst) begin
            m_k = 0; m_mode = M_NUM; m_t = 0; m_idx = 0; m_ft = 0; m_off = 0;
            m_prev_state = 4'd0; m_word = 20'd0;
            e_an = 4'b1111; e_seg = 5'd31; e_busy = 1'b0; e_ft = 1'b0;
        end else begin
            p_mode = m_mode; p_idx = m_idx; p_off = m_off; p_word = m_word;
            ft_prev = m_ft;
            m_k++;
            trig = (state != m_prev_state) && is_msg(state);
            m_prev_state = state;
            if (trig) begin
                m_mode = M_MSG; m_t = m_k; m_word = msg_code;
            end else if (m_mode == M_MSG && (m_k - m_t) >= HOLD) begin
                m_mode = M_BLANK;
            end else if (m_mode == M_BLANK && ft_prev) begin
                m_mode = M_NUM;
            end
            m_idx = (m_k / SCAN) % 4;
            m_ft  = (m_k % (4 * SCAN)) == 0;
            m_off = BLINK_ON && (m_mode == M_MSG) && (((m_k - m_t) / BLINK) % 2 == 1);
            if (p_mode == M_BLANK || (p_mode == M_MSG && p_off)) begin
                e_an = 4'b1111; e_seg = 5'd31;
            end else begin
                shown = (p_mode == M_MSG) ? p_word : num_code;
                e_an  = an_tbl[p_idx];
                e_seg = glyph_of(shown, p_idx);
            end
            e_busy = (m_mode != M_NUM);
            e_ft   = m_ft;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 4'd0; msg_code = 20'd0; num_code = pack4(1, 2, 3, 4);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {4'b1111, 5'd31, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=1111 seg=31 busy=0 ft=0",
                         i, an, seg_code, busy, frame_tick);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({an, seg_code} !== {4'b0111, 5'd1}) begin
            errors++;
            $display("FAIL first_slot: got an=%b seg=%0d, want an=0111 seg=1", an, seg_code);
        end
    endtask

    task automatic test_idle_scan();
        int ft_count;
        ft_count = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            ft_count += int'(frame_tick);
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL idle_scan[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
        checks++;
        if (ft_count != 2) begin
            errors++;
            $display("FAIL idle_frame_ticks: got %0d, want 2", ft_count);
        end
    endtask

    task automatic test_msg_timeout();
        int busy_cnt;
        busy_cnt = 0;
        state = 4'd6; msg_code = pack4(16, 14, 18, 20);
        for (int i = 0; i < 110; i++) begin
            if (i == 20) state = 4'd0;
            tick();
            busy_cnt += int'(busy);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL msg_busy_rise: got busy=%b, want 1", busy);
                end
            end
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL msg_timeout[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
        checks++;
        if (busy_cnt < HOLD || busy_cnt > HOLD + 4 * SCAN + 1) begin
            errors++;
            $display("FAIL msg_busy_len: got %0d cycles, want %0d..%0d", busy_cnt, HOLD, HOLD + 4 * SCAN + 1);
        end
    endtask

    task automatic test_retrigger();
        state = 4'd6; msg_code = pack4(16, 14, 18, 20);
        for (int i = 0; i < 150; i++) begin
            if (i == 40) begin
                state = 4'd8; msg_code = pack4(31, 12, 18, 10);
            end
            tick();
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL retrigger[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
    endtask

    task automatic test_no_trigger();
        int rises;
        logic last_busy;
        rises = 0; last_busy = busy;
        num_code = pack4(5, 6, 7, 8);
        state = 4'd0;
        for (int i = 0; i < 230; i++) begin
            if (i == 2)  state = 4'd7;
            if (i == 30) begin state = 4'd6; msg_code = pack4(2, 4, 6, 8); end
            tick();
            if (busy && !last_busy) rises++;
            last_busy = busy;
            if (i < 30) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL non_msg_state[%0d]: got busy=%b, want 0", i, busy);
                end
            end
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL no_trigger[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL steady_no_reshow: got %0d busy rises, want 1", rises);
        end
    endtask

    task automatic test_mid_reset();
        state = 4'd9; msg_code = pack4(3, 1, 4, 1);
        for (int i = 0; i < 40; i++) begin
            rst = (i == 20);
            tick();
            if (i == 20) begin
                checks++;
                if ({an, seg_code, busy, frame_tick} !== {4'b1111, 5'd31, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL mid_reset: got an=%b seg=%0d busy=%b ft=%b, want an=1111 seg=31 busy=0 ft=0",
                             an, seg_code, busy, frame_tick);
                end
            end
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                state    = 4'($urandom_range(0, 15));
                msg_code = 20'($urandom);
            end
            if ($urandom_range(0, 9) == 0) num_code = 20'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            tick();
            checks++;
            if ({an, seg_code, busy, frame_tick} !== {e_an, e_seg, e_busy, e_ft}) begin
                errors++;
                $display("FAIL random[%0d]: got an=%b seg=%0d busy=%b ft=%b, want an=%b seg=%0d busy=%b ft=%b",
                         i, an, seg_code, busy, frame_tick, e_an, e_seg, e_busy, e_ft);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; state = 4'd0; msg_code = 20'd0; num_code = 20'd0;
        @(negedge clk);
        test_reset();
        test_idle_scan();
        test_msg_timeout();
        test_retrigger();
        test_no_trigger();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
